// File: rtl/pc_fetch_sequencer.sv
// Multi-cycle fetch / next-PC controller for the MIPS core: owns the PC, fetches over a
// req/ack instruction-memory port and holds each instruction until the core retires it.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    input  logic        retire,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic [31:0] sign_imm,
    output logic        fetch_err
);

    localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    logic [1:0]        state;
    logic [31:0]       pc;
    logic [WAIT_W-1:0] wait_cnt;

    logic [31:0] pc4;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] next_pc;
    logic        next_misaligned;

    // Next-PC selection: jump beats jr beats taken branch; only jr can produce a misaligned target.
    always_comb begin
        pc4             = pc + 32'd4;
        jump_target     = {pc4[31:28], instr[25:0], 2'b00};
        branch_target   = pc4 + (sign_imm << 2);
        next_pc         = pc4;
        if (jump) begin
            next_pc = jump_target;
        end else if (jr) begin
            next_pc = jr_target;
        end else if (branch && zero) begin
            next_pc = branch_target;
        end
        next_misaligned = (next_pc[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            wait_cnt    <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            fetch_err   <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    // The request rises one cycle after reset; acks seen before that are dropped.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= ST_EXEC;
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt  <= wait_cnt + 1'b1;
                        fetch_err <= 1'b1;
                        imem_req  <= 1'b0;
                        state     <= ST_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (retire) begin
                        instr_valid <= 1'b0;
                        if (next_misaligned) begin
                            fetch_err <= 1'b1;
                            state     <= ST_HALT;
                        end else begin
                            pc       <= next_pc;
                            imem_req <= 1'b1;
                            wait_cnt <= '0;
                            state    <= ST_FETCH;
                        end
                    end
                end
                ST_HALT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    fetch_err   <= 1'b1;
                end
                default: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    fetch_err   <= 1'b1;
                    state       <= ST_HALT;
                end
            endcase
        end
    end

    assign imem_addr = pc;
    assign pc_out    = pc;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Testbench for pc_fetch_sequencer: directed fetch/retire sequences checked against a
// transaction-level model every cycle, plus hand-computed address expectations.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        retire = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic        jump = 1'b0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic [31:0] sign_imm = 32'h0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    pc_fetch_sequencer #(
        .RESET_PC(RESET_PC),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid),
        .instr(instr),
        .pc_out(pc_out),
        .retire(retire),
        .branch(branch),
        .zero(zero),
        .jump(jump),
        .jr(jr),
        .jr_target(jr_target),
        .sign_imm(sign_imm),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Next PC from the architectural rules, using wide arithmetic reduced modulo 2^32.
    function automatic logic [31:0] modelNext(input logic [31:0] pc, input logic [31:0] ins,
                                             input logic j, input logic r, input logic b, input logic z,
                                             input logic [31:0] tgt, input logic [31:0] imm);
        longint unsigned p4;
        longint unsigned res;
        p4 = ({32'h0, pc} + 64'd4) % 64'h1_0000_0000;
        if (j)
            res = (p4 - (p4 % 64'h1000_0000)) + ({32'h0, ins} % 64'h400_0000) * 64'd4;
        else if (r)
            res = {32'h0, tgt};
        else if (b && z)
            res = (p4 + {32'h0, imm} * 64'd4) % 64'h1_0000_0000;
        else
            res = p4;
        return res[31:0];
    endfunction

    logic        m_live = 1'b0;
    logic        m_req;
    logic        m_valid;
    logic        m_err;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    int          m_wait;

    // Reference model: tracks what the outputs must be after each clock edge.
    always @(posedge clk) begin
        logic [31:0] nxt;
        if (rst) begin
            m_live  = 1'b1;
            m_req   = 1'b0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_pc    = RESET_PC;
            m_instr = 32'h0;
            m_wait  = 0;
        end else if (m_live && !m_err) begin
            if (m_valid) begin
                if (retire) begin
                    nxt     = modelNext(m_pc, m_instr, jump, jr, branch, zero, jr_target, sign_imm);
                    m_valid = 1'b0;
                    if (nxt % 4 != 0) begin
                        m_err = 1'b1;
                    end else begin
                        m_pc   = nxt;
                        m_req  = 1'b1;
                        m_wait = 0;
                    end
                end
            end else if (!m_req) begin
                m_req = 1'b1;
            end else if (imem_ack) begin
                m_instr = imem_rdata;
                m_valid = 1'b1;
                m_req   = 1'b0;
            end else begin
                m_wait = m_wait + 1;
                if (m_wait == MAX_WAIT) begin
                    m_err = 1'b1;
                    m_req = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            checkOutput("cmp_req", {31'h0, imem_req}, {31'h0, m_req});
            checkOutput("cmp_valid", {31'h0, instr_valid}, {31'h0, m_valid});
            checkOutput("cmp_err", {31'h0, fetch_err}, {31'h0, m_err});
            if (m_req) checkOutput("cmp_addr", imem_addr, m_pc);
            if (m_valid) begin
                checkOutput("cmp_instr", instr, m_instr);
                checkOutput("cmp_pc", pc_out, m_pc);
            end
        end
    end

    task automatic applyStimulus(input logic ret, input logic br, input logic z, input logic j,
                                 input logic r, input logic [31:0] tgt, input logic [31:0] imm);
        retire    = ret;
        branch    = br;
        zero      = z;
        jump      = j;
        jr        = r;
        jr_target = tgt;
        sign_imm  = imm;
    endtask

    task automatic retireWith(input logic br, input logic z, input logic j, input logic r,
                              input logic [31:0] tgt, input logic [31:0] imm);
        applyStimulus(1'b1, br, z, j, r, tgt, imm);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic waitReq(input string name);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_req_wait: got imem_req=%b, expected 1 within 20 cycles", name, imem_req);
        end
    endtask

    // Waits for a request, checks its address, stalls 'delay' cycles, then acks with 'word'.
    task automatic fetchWord(input string name, input logic [31:0] exp_addr, input logic [31:0] word,
                             input int delay, input logic stray_retire);
        waitReq(name);
        checkOutput({name, "_addr"}, imem_addr, exp_addr);
        retire = stray_retire;
        repeat (delay) @(negedge clk);
        retire     = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        checkOutput({name, "_valid"}, {31'h0, instr_valid}, 32'h1);
        checkOutput({name, "_instr"}, instr, word);
        checkOutput({name, "_pc"}, pc_out, exp_addr);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int k;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_req", {31'h0, imem_req}, 32'h0);
        checkOutput("rst_valid", {31'h0, instr_valid}, 32'h0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_err", {31'h0, fetch_err}, 32'h0);
        checkOutput("rst_pc", pc_out, RESET_PC);

        // A stray ack before the first request must be ignored.
        rst      = 1'b0;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        checkOutput("first_req", {31'h0, imem_req}, 32'h1);
        checkOutput("first_valid", {31'h0, instr_valid}, 32'h0);

        // Sequential fetches, with stalls and a retire pulse while nothing is valid.
        fetchWord("t1a", 32'h0000_0000, 32'h2108_0001, 0, 1'b0);
        retireWith(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetchWord("t1b", 32'h0000_0004, 32'h0000_0000, 1, 1'b1);
        retireWith(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetchWord("t1c", 32'h0000_0008, 32'h1234_5678, 2, 1'b1);
        retireWith(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Jump into 0x0040_0010, then taken branch backwards by 2 words.
        fetchWord("jmp1", 32'h0000_000C, 32'h0810_0004, 0, 1'b0);
        retireWith(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        fetchWord("t2", 32'h0040_0010, 32'hAAAA_5555, 0, 1'b0);
        retireWith(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFE);
        fetchWord("t2b", 32'h0040_000C, 32'h1000_0003, 0, 1'b0);
        retireWith(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0010);

        // All three redirects at once: jump wins; then jr beats branch.
        fetchWord("prio", 32'h0040_0010, 32'h0800_0040, 0, 1'b0);
        retireWith(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0102, 32'h0000_0100);
        fetchWord("jrb", 32'h0000_0100, 32'h5555_AAAA, 1, 1'b0);
        retireWith(1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0000, 32'h0000_0004);

        fetchWord("t3", 32'h1000_0000, 32'h0000_0040, 0, 1'b0);
        retireWith(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

        // PC wrap-around at the top of the address space.
        fetchWord("jrw", 32'h1000_0100, 32'hDEAD_BEEF, 0, 1'b0);
        retireWith(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
        fetchWord("wrap", 32'hFFFF_FFFC, 32'hCAFE_F00D, 0, 1'b0);
        retireWith(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset colliding with an ack mid-fetch.
        fetchWord("t6pre", 32'h0000_0000, 32'h0000_0040, 0, 1'b0);
        retireWith(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        waitReq("t6");
        checkOutput("t6_addr", imem_addr, 32'h0000_0100);
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_2222;
        @(negedge clk);
        checkOutput("t6_req", {31'h0, imem_req}, 32'h0);
        checkOutput("t6_valid", {31'h0, instr_valid}, 32'h0);
        checkOutput("t6_pc", pc_out, RESET_PC);
        rst      = 1'b0;
        imem_ack = 1'b0;

        // Misaligned jr halts until reset, ignoring acks meanwhile.
        fetchWord("t4", 32'h0000_0000, 32'h03E0_0008, 0, 1'b0);
        retireWith(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0102, 32'h0);
        checkOutput("t4_err", {31'h0, fetch_err}, 32'h1);
        checkOutput("t4_req", {31'h0, imem_req}, 32'h0);
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        imem_ack = 1'b0;
        checkOutput("t4_halt_req", {31'h0, imem_req}, 32'h0);
        checkOutput("t4_halt_err", {31'h0, fetch_err}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t4_rst_req", {31'h0, imem_req}, 32'h1);
        checkOutput("t4_rst_addr", imem_addr, RESET_PC);
        checkOutput("t4_rst_err", {31'h0, fetch_err}, 32'h0);

        // Ack timeout: the request is held for exactly MAX_WAIT cycles.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        k = 0;
        while (fetch_err !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
            if (imem_req === 1'b1) n++;
        end
        checkOutput("t5_wait_cycles", n, 32'd4);
        checkOutput("t5_err", {31'h0, fetch_err}, 32'h1);
        checkOutput("t5_req", {31'h0, imem_req}, 32'h0);
        repeat (2) @(negedge clk);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
